// File: rtl/gearbox_pkg.sv
// Shared constants for the 40-to-66 receive gearbox and its 66-to-40 transmit twin.
package gearbox_pkg;

    localparam int GB_IN_W       = 40;
    localparam int GB_OUT_W      = 66;
    localparam int GB_STOR_W     = 105;
    localparam int GB_PERIOD_IN  = 33;
    localparam int GB_PERIOD_OUT = 20;
    // Fill count must reach GB_STOR_W (65 + 40) without wrapping.
    localparam int GB_CNT_W      = 7;

endpackage

// File: rtl/gearbox_40_66.sv
// 40-bit to 66-bit receive gearbox, lsbit first on both sides.
// Defining GEARBOX_40_66_SLIP_EN enables the one-bit slip on din[0].
module gearbox_40_66
    import gearbox_pkg::*;
(
    input  logic                clk,
    input  logic                sclr,
    input  logic [GB_IN_W-1:0]  din,
    input  logic                din_valid,
    input  logic                slip,
    output logic [GB_OUT_W-1:0] dout,
    output logic                dout_valid
);

    logic [GB_CNT_W-1:0]  h_q, h_d;
    logic [GB_STOR_W-1:0] store_q, store_d;
    logic [GB_OUT_W-1:0]  dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    logic [GB_STOR_W-1:0] word_ext;
    logic [GB_STOR_W-1:0] keep_mask;
    logic [GB_STOR_W-1:0] merged;
    logic [GB_CNT_W-1:0]  n;

`ifndef GEARBOX_40_66_SLIP_EN
    logic unused_slip;
    assign unused_slip = slip;
`endif

    always_comb begin
        word_ext = GB_STOR_W'(din);
        n        = h_q + GB_CNT_W'(GB_IN_W);
`ifdef GEARBOX_40_66_SLIP_EN
        if (slip) begin
            word_ext = GB_STOR_W'(din[GB_IN_W-1:1]);
            n        = h_q + GB_CNT_W'(GB_IN_W - 1);
        end
`endif
        // Store bits at and above h are stale (sclr never clears the store), so mask them out.
        keep_mask = ~({GB_STOR_W{1'b1}} << h_q);
        merged    = (store_q & keep_mask) | (word_ext << h_q);

        h_d          = h_q;
        store_d      = store_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        if (sclr) begin
            h_d = '0;
        end else if (din_valid) begin
            if (n >= GB_CNT_W'(GB_OUT_W)) begin
                dout_d       = merged[GB_OUT_W-1:0];
                dout_valid_d = 1'b1;
                store_d      = merged >> GB_OUT_W;
                h_d          = n - GB_CNT_W'(GB_OUT_W);
            end else begin
                store_d = merged;
                h_d     = n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            h_q          <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Data path has no reset; it powers up to zero and otherwise holds.
    always_ff @(posedge clk) begin
        store_q <= store_d;
        dout_q  <= dout_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_gearbox_40_66.sv
// Self-checking bench for gearbox_40_66 against a bit-queue line model.
// Builds with or without GEARBOX_40_66_SLIP_EN.
module tb_gearbox_40_66;

    logic        clk = 1'b0;
    logic        sclr = 1'b0;
    logic [39:0] din = '0;
    logic        din_valid = 1'b0;
    logic        slip = 1'b0;
    logic [65:0] dout;
    logic        dout_valid;

`ifdef GEARBOX_40_66_SLIP_EN
    localparam bit SLIP_EN = 1'b1;
`else
    localparam bit SLIP_EN = 1'b0;
`endif

    gearbox_40_66 dut (
        .clk        (clk),
        .sclr       (sclr),
        .din        (din),
        .din_valid  (din_valid),
        .slip       (slip),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Line model: received bits in arrival order.
    bit          line_q[$];
    logic [65:0] exp_dout = '0;
    logic        exp_valid = 1'b0;
    int          exp_h = 0;
    bit          dout_known = 1'b0;
    logic [65:0] exp_q[$];
    logic [65:0] rx_blocks[$];

    task automatic step(input logic [39:0] d, input logic v, input logic s, input logic r);
        sclr      = r;
        din       = d;
        din_valid = v;
        slip      = s;
        @(posedge clk);
        #1;
        if (r) begin
            line_q.delete();
            exp_valid = 1'b0;
        end else if (v) begin
            for (int i = (SLIP_EN && s) ? 1 : 0; i < 40; i++) line_q.push_back(d[i]);
            if (line_q.size() >= 66) begin
                for (int i = 0; i < 66; i++) exp_dout[i] = line_q.pop_front();
                exp_valid  = 1'b1;
                dout_known = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
        exp_h = line_q.size();
    endtask

    function automatic logic [65:0] rand66();
        return {$urandom_range(3, 0), $urandom, $urandom};
    endfunction

    task automatic test_reset();
        step('0, 1'b1, 1'b1, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", dout_valid);
        end
        total++;
        if (dut.h_q !== 7'd0) begin
            bad++; $display("FAIL reset_h got=%0d want=0", dut.h_q);
        end
    endtask

    task automatic test_first_block();
        step('0, 1'b0, 1'b0, 1'b1);
        step(40'h00000_00001, 1'b1, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || dut.h_q !== 7'd40) begin
            bad++; $display("FAIL first_word0 valid=%b h=%0d want valid=0 h=40", dout_valid, dut.h_q);
        end
        step(40'hFFFFF_FFFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 66'h3_FFFFFF_00000_00001 || dut.h_q !== 7'd14) begin
            bad++; $display("FAIL first_block valid=%b dout=%h h=%0d want 1 %h 14",
                            dout_valid, dout, dut.h_q, 66'h3_FFFFFF_00000_00001);
        end
        step('0, 1'b0, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || dout !== exp_dout) begin
            bad++; $display("FAIL first_hold valid=%b dout=%h want 0 %h", dout_valid, dout, exp_dout);
        end
    endtask

    task automatic test_gaps();
        step('0, 1'b0, 1'b0, 1'b1);
        step(40'h00000_00001, 1'b1, 1'b0, 1'b0);
        step(40'h12345_6789A, 1'b0, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || dut.h_q !== 7'd40) begin
            bad++; $display("FAIL gap_idle valid=%b h=%0d want 0 40", dout_valid, dut.h_q);
        end
        step(40'hFFFFF_FFFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 66'h3_FFFFFF_00000_00001) begin
            bad++; $display("FAIL gap_block valid=%b dout=%h want 1 %h",
                            dout_valid, dout, 66'h3_FFFFFF_00000_00001);
        end
        step('0, 1'b0, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || dout !== 66'h3_FFFFFF_00000_00001 || dut.h_q !== 7'd14) begin
            bad++; $display("FAIL gap_hold valid=%b dout=%h h=%0d", dout_valid, dout, dut.h_q);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] held;
        step('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step({$urandom, $urandom_range(255, 0)}, 1'b1, 1'b0, 1'b0);
        total++;
        if (dut.h_q !== 7'd54 || 7'(exp_h) !== 7'd54) begin
            bad++; $display("FAIL mid_h54 h=%0d model=%0d want 54", dut.h_q, exp_h);
        end
        held = exp_dout;
        step({$urandom, $urandom_range(255, 0)}, 1'b1, 1'b1, 1'b1);
        total++;
        if (dout_valid !== 1'b0 || dut.h_q !== 7'd0 || dout !== held) begin
            bad++; $display("FAIL mid_reset valid=%b h=%0d dout=%h want 0 0 %h", dout_valid, dut.h_q, dout, held);
        end
        step(40'h00000_00001, 1'b1, 1'b0, 1'b0);
        step(40'hFFFFF_FFFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 66'h3_FFFFFF_00000_00001 || dut.h_q !== 7'd14) begin
            bad++; $display("FAIL mid_block valid=%b dout=%h h=%0d", dout_valid, dout, dut.h_q);
        end
    endtask

    // Random words, random gaps, random slip; every cycle checked against the line model.
    task automatic test_random_slip();
        int errs = 0;
        step('0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            step({$urandom, $urandom_range(255, 0)}, 1'($urandom_range(1, 0)),
                 1'($urandom_range(3, 0) == 0), 1'b0);
            total++;
            if (dout_valid !== exp_valid || dut.h_q !== 7'(exp_h) ||
                (dout_known && dout !== exp_dout)) begin
                bad++; errs++;
                if (errs < 5)
                    $display("FAIL random c=%0d valid=%b/%b h=%0d/%0d dout=%h/%h",
                             c, dout_valid, exp_valid, dut.h_q, exp_h, dout, exp_dout);
            end
        end
    endtask

    // Loopback from an ideal 66-to-40 serializer: line bits are the blocks back to back.
    task automatic test_loopback();
        bit tx_q[$];
        int hits[$];
        logic [65:0] blk;
        logic [39:0] w;
        int pattern[20] = '{1, 3, 4, 6, 8, 9, 11, 13, 14, 16, 18, 19, 21, 23, 24, 26, 28, 29, 31, 32};
        exp_q.delete();
        for (int b = 0; b < 60; b++) begin
            blk = rand66();
            exp_q.push_back(blk);
            for (int i = 0; i < 66; i++) tx_q.push_back(blk[i]);
        end
        step('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 99; k++) begin
            for (int i = 0; i < 40; i++) w[i] = tx_q.pop_front();
            step(w, 1'b1, 1'b0, 1'b0);
            if (dout_valid === 1'b1) begin
                hits.push_back(k);
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL loop_extra word=%0d dout=%h", k, dout);
                end else begin
                    blk = exp_q.pop_front();
                    if (dout !== blk) begin
                        bad++; $display("FAIL loop_data word=%0d got=%h want=%h", k, dout, blk);
                    end
                end
            end
        end
        total++;
        if (hits.size() != 60 || exp_q.size() != 0 || dut.h_q !== 7'd0) begin
            bad++; $display("FAIL loop_count blocks=%0d left=%0d h=%0d want 60 0 0",
                            hits.size(), exp_q.size(), dut.h_q);
        end
        for (int i = 0; i < hits.size() && i < 60; i++) begin
            total++;
            if (hits[i] != pattern[i % 20] + 33 * (i / 20)) begin
                bad++; $display("FAIL loop_phase block=%0d word=%0d want=%0d",
                                i, hits[i], pattern[i % 20] + 33 * (i / 20));
            end
        end
    endtask

`ifdef GEARBOX_40_66_SLIP_EN
    // One slip on word 0 advances the stream by a bit; 66 slips restore block alignment.
    task automatic test_slip_align();
        bit tx_q[$];
        bit ref_q[$];
        logic [65:0] sent[$];
        logic [65:0] blk;
        logic [39:0] w;
        for (int b = 0; b < 62; b++) begin
            blk = rand66();
            sent.push_back(blk);
            for (int i = 0; i < 66; i++) tx_q.push_back(blk[i]);
        end
        ref_q = tx_q;
        void'(ref_q.pop_front());
        step('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 40; i++) w[i] = tx_q[k * 40 + i];
            step(w, 1'b1, 1'(k == 0), 1'b0);
            if (dout_valid === 1'b1) begin
                for (int i = 0; i < 66; i++) blk[i] = ref_q.pop_front();
                total++;
                if (dout !== blk) begin
                    bad++; $display("FAIL slip1 word=%0d got=%h want=%h", k, dout, blk);
                end
            end
        end
        rx_blocks.delete();
        step('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 40; i++) w[i] = tx_q[k * 40 + i];
            step(w, 1'b1, 1'(k < 66), 1'b0);
            if (dout_valid === 1'b1) rx_blocks.push_back(dout);
        end
        total++;
        if (rx_blocks.size() != 59) begin
            bad++; $display("FAIL slip66_count got=%0d want=59", rx_blocks.size());
        end
        for (int i = 49; i < 59 && i < rx_blocks.size(); i++) begin
            total++;
            if (rx_blocks[i] !== sent[i + 1]) begin
                bad++; $display("FAIL slip66_align block=%0d got=%h want=%h", i, rx_blocks[i], sent[i + 1]);
            end
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_block();
        test_gaps();
        test_reset_mid();
        test_loopback();
        test_random_slip();
`ifdef GEARBOX_40_66_SLIP_EN
        test_slip_align();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gearbox_40_66.md
GEARBOX_40_66 -- requirements
Module: gearbox_40_66

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-002 SHALL have port sclr, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port din, input, 40 bits: receive word; bit 0 is the oldest bit on the line (lsbit first).
REQ-004 SHALL have port din_valid, input, 1 bit: din carries a new word this cycle.
REQ-005 SHALL have port slip, input, 1 bit: discard one line bit to shift block alignment; sampled only with din_valid.
REQ-006 SHALL have port dout, output, 66 bits: reassembled block, lsbit first.
REQ-007 SHALL have port dout_valid, output, 1 bit: dout holds a new block this cycle; single-cycle pulse per block.

Function
REQ-008 SHALL keep a fill count h (0..65) of buffered line bits and a 105-bit store whose bits [h-1:0] hold those bits, oldest at bit 0.
REQ-009 SHALL do nothing on a cycle with din_valid low: h and the store hold, and dout_valid is low on the next cycle.
REQ-010 SHALL, on a cycle with din_valid high and slip low, append din[39:0] at store bit h, giving n = h+40.
REQ-011 SHALL, if n >= 66 after an append, register store[65:0] to dout, pulse dout_valid, shift the remainder down, and set h = n-66; otherwise set h = n with dout_valid low.
REQ-012 SHALL register dout and dout_valid at the clock edge that accepts the completing word: latency is 1 cycle from that din_valid to dout_valid.
REQ-013 SHALL hold dout at its last value while dout_valid is low.
REQ-014 SHALL, with continuous din_valid from h=0, produce exactly 20 blocks per 33 input words, then return to h=0.
REQ-015 SHALL give this dout_valid pattern, indexed by the input word that completes a block (word 0 first): words 1,3,4,6,8,9,11,13,14,16,18,19,21,23,24,26,28,29,31,32; the pattern repeats every 33 words.
REQ-016 SHALL implement h as a binary counter, not a fixed 33-state sequence, so that slip can move the phase arbitrarily.
REQ-017 SHALL give sclr priority over din_valid and slip in the same cycle.

Reset
REQ-018 SHALL, while sclr is high, set h=0 and dout_valid=0 on the next edge.
REQ-019 SHALL NOT have sclr clear the store or dout, to keep reset fanout small; both power up to 0 and otherwise hold.
REQ-020 SHALL discard any partial block on sclr asserted mid-operation; the first word after sclr is treated as word 0.

Configuration
REQ-021 SHALL, with macro GEARBOX_40_66_SLIP_EN defined, make a cycle with din_valid=1 and slip=1 append only din[39:1] at bit h (din[0] dropped), giving n = h+39, then apply REQ-011.
REQ-022 SHALL ignore slip when din_valid=0, and SHALL treat consecutive slip cycles as independent one-bit drops.
REQ-023 SHALL, without GEARBOX_40_66_SLIP_EN, keep the slip port present but ignore it entirely, and SHALL synthesize no slip logic.

Structure
REQ-024 SHALL take its constants from shared package gearbox_pkg: GB_IN_W=40, GB_OUT_W=66, GB_STOR_W=105, GB_PERIOD_IN=33, GB_PERIOD_OUT=20.
REQ-025 SHALL be a single flat module; no sub-module is warranted, and the shifter and count are inline.
REQ-026 SHALL be the receive counterpart of the 66-to-40 transmit gearbox: its output is bit-exact with the 66-bit blocks fed to that transmitter.

Verification
REQ-027 SHALL cover loopback: random 66-bit blocks through the 66-to-40 transmit gearbox into this block, din_valid tied high after alignment -> dout equals the sent blocks in order, 20 per 33 cycles.
REQ-028 SHALL cover first-block check: sclr, then din = 40'h00000_00001 followed by 40'hFFFFF_FFFFF -> one cycle after word 1, dout_valid=1 and dout = 66'h3_FFFFFF_00000_00001 (bits 65:40 all ones), h=14.
REQ-029 SHALL cover gaps: din_valid toggled 1,0,1,0 with the words of REQ-028 -> identical dout, and dout_valid one cycle after the second valid word.
REQ-030 SHALL cover slip (macro on): one slip on word 0 -> all subsequent dout are the unslipped line stream advanced by one bit; 66 single slips -> dout alignment identical to no slip.
REQ-031 SHALL cover slip (macro off): slip toggled randomly -> output identical to the slip=0 run.
REQ-032 SHALL cover reset mid-operation: sclr at h=54 together with din_valid=1 and slip=1 -> next cycle dout_valid=0, h=0, dout unchanged; the next two words produce the block of REQ-028.
